// File: rtl/bcd_stopwatch_ctrl_if.sv
// Control and status bundle for the BCD stopwatch controller.
// The master side drives the requests and the slave side returns the registered status.
interface bcd_stopwatch_ctrl_if;
  logic        start;
  logic        stop;
  logic        clear;
  logic        lap;
  logic [15:0] count;
  logic [15:0] lap_count;
  logic [1:0]  state;
  logic        running;
  logic        carry_out;

  modport master (
    output start, stop, clear, lap,
    input  count, lap_count, state, running, carry_out
  );

  modport slave (
    input  start, stop, clear, lap,
    output count, lap_count, state, running, carry_out
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Four-digit BCD stopwatch: IDLE/RUN/PAUSE control, a TICK_DIV-cycle prescaler and lap capture.
// Every status output comes straight from a flop.
module bcd_stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic               clk,
  input  logic               rst,
  bcd_stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } state_e;

  localparam logic [15:0] PRESC_TERM = 16'(TICK_DIV - 32'd1);

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] count_q, count_d;
  logic [15:0] lap_q, lap_d;
  logic        carry_q, carry_d;
  logic        running_q, running_d;

  // Decimal increment; a digit at 9 (or a corrupted value above 9) rolls to 0 and carries.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Next-state, prescaler, count and lap logic; clear overrides everything else.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    lap_d   = lap_q;
    carry_d = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      presc_d = 16'd0;
      count_d = 16'h0000;
      lap_d   = 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = 16'd0;
          state_d = (!bus.stop && bus.start) ? ST_RUN : ST_IDLE;
        end
        ST_RUN: begin
          lap_d = bus.lap ? count_q : lap_q;
          // A stop still lets a terminal tick land; otherwise the prescaler freezes where it is.
          if (presc_q == PRESC_TERM) begin
            count_d = bcd_inc(count_q);
            carry_d = (count_q == 16'h9999);
            presc_d = 16'd0;
          end else if (!bus.stop) begin
            presc_d = presc_q + 16'd1;
          end else begin
            presc_d = presc_q;
          end
          state_d = bus.stop ? ST_PAUSE : ST_RUN;
        end
        ST_PAUSE: begin
          lap_d   = bus.lap ? count_q : lap_q;
          state_d = (!bus.stop && bus.start) ? ST_RUN : ST_PAUSE;
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = 16'd0;
          count_d = 16'h0000;
          lap_d   = 16'h0000;
        end
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= 16'd0;
      count_q   <= 16'h0000;
      lap_q     <= 16'h0000;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      lap_q     <= lap_d;
      carry_q   <= carry_d;
      running_q <= running_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.lap_count = lap_q;
  assign bus.state     = state_q;
  assign bus.running   = running_q;
  assign bus.carry_out = carry_q;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Scoreboard bench: two stopwatches (TICK_DIV 4 and 1) share stimulus; a decimal reference
// model predicts every cycle's outputs and a monitor compares them after each rising edge.
module tb_bcd_stopwatch_ctrl;

  typedef struct {
    logic [15:0] count;
    logic [15:0] lap;
    logic [1:0]  st;
    logic        run;
    logic        carry;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t q4[$];
  exp_t q1[$];

  // Reference state, index 0 = TICK_DIV 4, index 1 = TICK_DIV 1.
  int td[2]    = '{4, 1};
  int m_st[2]  = '{0, 0};
  int m_n[2]   = '{0, 0};
  int m_lap[2] = '{0, 0};
  int m_p[2]   = '{0, 0};
  bit m_c[2]   = '{1'b0, 1'b0};

  bcd_stopwatch_ctrl_if if4();
  bcd_stopwatch_ctrl_if if1();

  bcd_stopwatch_ctrl #(.TICK_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  bcd_stopwatch_ctrl #(.TICK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  task automatic model_step(input int k, input bit r, input bit s, input bit p,
                            input bit c, input bit l);
    exp_t e;
    if (r || c) begin
      m_st[k] = 0; m_n[k] = 0; m_lap[k] = 0; m_p[k] = 0; m_c[k] = 1'b0;
    end else begin
      m_c[k] = 1'b0;
      if (m_st[k] == 0) begin
        m_p[k] = 0;
        if (!p && s) m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        if (l) m_lap[k] = m_n[k];
        if (m_p[k] == td[k] - 1) begin
          m_c[k] = (m_n[k] == 9999);
          m_n[k] = (m_n[k] + 1) % 10000;
          m_p[k] = 0;
        end else if (!p) begin
          m_p[k] = m_p[k] + 1;
        end
        if (p) m_st[k] = 2;
      end else begin
        if (l) m_lap[k] = m_n[k];
        if (!p && s) m_st[k] = 1;
      end
    end
    e.count = to_bcd(m_n[k]);
    e.lap   = to_bcd(m_lap[k]);
    e.st    = 2'(m_st[k]);
    e.run   = (m_st[k] == 1);
    e.carry = m_c[k];
    if (k == 0) q4.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit s, input bit p, input bit c, input bit l);
    @(negedge clk);
    rst = r;
    if4.start = s; if4.stop = p; if4.clear = c; if4.lap = l;
    if1.start = s; if1.stop = p; if1.clear = c; if1.lap = l;
    model_step(0, r, s, p, c, l);
    model_step(1, r, s, p, c, l);
  endtask

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // Monitor: pops one prediction per DUT after every rising edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      chk("td4.count",     if4.count,            e.count);
      chk("td4.lap_count", if4.lap_count,        e.lap);
      chk("td4.state",     16'(if4.state),       16'(e.st));
      chk("td4.running",   16'(if4.running),     16'(e.run));
      chk("td4.carry_out", 16'(if4.carry_out),   16'(e.carry));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("td1.count",     if1.count,            e.count);
      chk("td1.lap_count", if1.lap_count,        e.lap);
      chk("td1.state",     16'(if1.state),       16'(e.st));
      chk("td1.running",   16'(if1.running),     16'(e.run));
      chk("td1.carry_out", 16'(if1.carry_out),   16'(e.carry));
    end
  end

  initial begin
    if4.start = 1'b0; if4.stop = 1'b0; if4.clear = 1'b0; if4.lap = 1'b0;
    if1.start = 1'b0; if1.stop = 1'b0; if1.clear = 1'b0; if1.lap = 1'b0;

    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Start, pause with the TICK_DIV=4 prescaler at 2, hold, resume, run on.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (45) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Lap, start+stop together, then clear+start+lap from PAUSE.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    // Reset mid-RUN with start held, then restart.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Long run so the TICK_DIV=1 instance crosses 0999 and wraps 9999.
    for (int i = 0; i < 10010; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 299) == 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
          $urandom_range(0, 7) == 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q4.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q4.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 10, clock cycles per count increment; legal range 1..65535.
REQ-002 SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  level-sampled run request.
REQ-005 SHALL provide port stop  input  1  level-sampled pause request.
REQ-006 SHALL provide port clear  input  1  return to IDLE, zero all counts.
REQ-007 SHALL provide port lap  input  1  capture current count into lap_count.
REQ-008 SHALL provide port count  output  16  four BCD digits; [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
REQ-009 SHALL provide port lap_count  output  16  last captured count, same digit layout.
REQ-010 SHALL provide port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
REQ-011 SHALL provide port running  output  1  high exactly when state is RUN.
REQ-012 SHALL provide port carry_out  output  1  one-cycle pulse on 9999->0000 wrap.
REQ-013 SHALL register every output; no combinational input-to-output path.

Function
REQ-014 FSM transitions SHALL be: IDLE --start--> RUN; RUN --stop--> PAUSE; PAUSE --start--> RUN; any state --clear--> IDLE.
REQ-015 Input priority SHALL be clear > stop > start; with start and stop both high, IDLE and PAUSE hold, RUN goes to PAUSE.
REQ-016 Encoding 11 SHALL be unreachable; if entered, next edge SHALL go to IDLE with counts zeroed.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 while RUN; hold its value in PAUSE; be zero in IDLE.
REQ-018 When state is RUN and prescaler equals TICK_DIV-1, the edge SHALL increment count and return prescaler to 0.
REQ-019 Increment decision SHALL use the pre-edge state; stop sampled on a terminal-tick edge still allows that increment.
REQ-020 First increment after start sampled in IDLE SHALL appear TICK_DIV edges after the start edge.
REQ-021 TICK_DIV=1 SHALL increment count on every RUN edge.
REQ-022 Increment SHALL be decimal: digit 9 -> 0 with carry into next digit; no digit SHALL ever hold a value above 9.
REQ-023 Count 9999 incrementing SHALL give 0000, with carry_out high for that one cycle only.
REQ-024 lap high in RUN or PAUSE SHALL load lap_count with the pre-edge count; lap in IDLE SHALL be ignored.
REQ-025 lap coincident with an increment SHALL capture the pre-increment value.
REQ-026 clear SHALL zero count, lap_count, prescaler, carry_out on the next edge, overriding lap and increment.

Reset
REQ-027 rst high at a rising edge SHALL force state IDLE, count 0x0000, lap_count 0x0000, prescaler 0, running 0, carry_out 0.
REQ-028 rst SHALL override all other inputs, including mid-RUN; no increment or lap capture SHALL occur on a reset edge.
REQ-029 After rst deasserts, the block SHALL stay IDLE until start is sampled.

Verification
REQ-030 TICK_DIV=4, reset, start 1 cycle -> count 0x0001 exactly 4 edges after start edge; 0x0010 after 40 edges; running=1.
REQ-031 TICK_DIV=1, run from 0x0999 -> next edge 0x1000; run from 9999 -> 0x0000 with carry_out high one cycle, low after.
REQ-032 TICK_DIV=4, stop when prescaler=2, hold 20 cycles -> count unchanged, state 10; start -> next increment 2 edges after resume edge.
REQ-033 In PAUSE with count 0x0042, assert clear+start+lap together -> state 00, count 0x0000, lap_count 0x0000.
REQ-034 TICK_DIV=1, lap when count 0x0037 -> lap_count 0x0037 next cycle while count reads 0x0038 and keeps counting.
REQ-035 Assert rst mid-RUN with start held high -> next edge all outputs zero, state 00; after rst drops, start -> RUN.
